cpu_dcache: RTL and testbench

- Direct-mapped, write-through, write-allocate, one-word-per-line data cache.
- Sits between the CPU memory stage (request side) and the system bus (bus side).
- All CPU accesses are aligned 32-bit words. The memory stage handles sub-word stores with read-modify-write, so the cache never sees byte enables.
- Read hits complete without a bus access. Read misses fill the line from the bus. Every write goes to the bus and also updates the line.

---
 rtl/cpu_dcache.sv | 146 ++++++++++++++
 tb/tb_cpu_dcache.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_dcache.sv
// cpu_dcache: direct-mapped, write-through, write-allocate data cache with
// one 32-bit word per line, between the CPU memory stage and the system bus.
// Optional build macro DCACHE_UNCACHED_IO_EN: addresses with bit 31 set are
// treated as uncacheable I/O (always go to the bus, never allocate a line).
module cpu_dcache #(
  parameter int INDEX_BITS = 8
) (
  input  logic        i_clock,
  input  logic        i_reset,
  output logic        o_bus_rw,
  output logic        o_bus_request,
  input  logic        i_bus_ready,
  output logic [31:0] o_bus_address,
  input  logic [31:0] i_bus_rdata,
  output logic [31:0] o_bus_wdata,
  input  logic        i_rw,
  input  logic        i_request,
  output logic        o_ready,
  input  logic [31:0] i_address,
  output logic [31:0] o_rdata,
  input  logic [31:0] i_wdata
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 30 - INDEX_BITS;

  typedef enum logic [1:0] {IDLE, LOOKUP, BUS_READ, BUS_WRITE} state_t;

  state_t state;

  // Valid bits are flops so reset can clear them all at once.
  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tag_ram  [LINES];
  logic [31:0]      data_ram [LINES];

  // Request captured at acceptance, plus the line read out for LOOKUP.
  logic [31:2]      lat_addr;
  logic             lat_rw;
  logic [31:0]      lat_wdata;
  logic [TAG_W-1:0] rd_tag;
  logic [31:0]      rd_data;
  logic             rd_valid;

  logic [INDEX_BITS-1:0] req_index;
  logic [INDEX_BITS-1:0] lat_index;
  logic [TAG_W-1:0]      lat_tag;
  logic                  start;
  logic                  cacheable;
  logic                  hit;
  logic                  fill_en;
  logic [31:0]           fill_data;
  logic                  unused_addr_bits;

  assign req_index = i_address[INDEX_BITS+1:2];
  assign lat_index = lat_addr[INDEX_BITS+1:2];
  assign lat_tag   = lat_addr[31:INDEX_BITS+2];

  // Word-aligned accesses only; the byte offset carries no information.
  assign unused_addr_bits = &{1'b0, i_address[1:0]};

`ifdef DCACHE_UNCACHED_IO_EN
  assign cacheable = !lat_addr[31];
`else
  assign cacheable = 1'b1;
`endif

  // A request is not accepted in the completion cycle: the requester is
  // still holding i_request high while it observes o_ready.
  assign start     = (state == IDLE) && i_request && !o_ready;
  assign hit       = rd_valid && (rd_tag == lat_tag) && cacheable;
  assign fill_en   = ((state == BUS_READ) || (state == BUS_WRITE)) &&
                     i_bus_ready && cacheable;
  assign fill_data = (state == BUS_READ) ? i_bus_rdata : lat_wdata;

  // Control FSM with registered CPU and bus outputs.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state         <= IDLE;
      o_bus_request <= 1'b0;
      o_bus_rw      <= 1'b0;
      o_bus_address <= '0;
      o_bus_wdata   <= '0;
      o_ready       <= 1'b0;
      o_rdata       <= '0;
    end else begin
      o_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (start) state <= LOOKUP;
        end
        LOOKUP: begin
          if (!lat_rw && hit) begin
            o_ready <= 1'b1;
            o_rdata <= rd_data;
            state   <= IDLE;
          end else begin
            o_bus_request <= 1'b1;
            o_bus_rw      <= lat_rw;
            o_bus_address <= {lat_addr, 2'b00};
            if (lat_rw) begin
              o_bus_wdata <= lat_wdata;
              state       <= BUS_WRITE;
            end else begin
              state <= BUS_READ;
            end
          end
        end
        BUS_READ, BUS_WRITE: begin
          if (i_bus_ready) begin
            o_bus_request <= 1'b0;
            o_ready       <= 1'b1;
            o_rdata       <= fill_data;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Valid bits: cleared by reset, set when a line is filled or allocated.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      valid <= '0;
    end else if (fill_en) begin
      valid[lat_index] <= 1'b1;
    end
  end

  // Request capture, tag/data RAM read at acceptance and line fill.
  always_ff @(posedge i_clock) begin
    if (start) begin
      lat_addr  <= i_address[31:2];
      lat_rw    <= i_rw;
      lat_wdata <= i_wdata;
      rd_tag    <= tag_ram[req_index];
      rd_data   <= data_ram[req_index];
      rd_valid  <= valid[req_index];
    end
    if (fill_en) begin
      tag_ram[lat_index]  <= lat_tag;
      data_ram[lat_index] <= fill_data;
    end
  end

endmodule

// File: tb/tb_cpu_dcache.sv
// Self-checking bench for cpu_dcache: a bus memory responder, a CPU-side
// driver that pushes expected read data into a scoreboard queue, and a
// monitor that pops and compares on every o_ready pulse.
module tb_cpu_dcache;

  logic        i_clock;
  logic        i_reset;
  logic        o_bus_rw;
  logic        o_bus_request;
  logic        i_bus_ready;
  logic [31:0] o_bus_address;
  logic [31:0] i_bus_rdata;
  logic [31:0] o_bus_wdata;
  logic        i_rw;
  logic        i_request;
  logic        o_ready;
  logic [31:0] i_address;
  logic [31:0] o_rdata;
  logic [31:0] i_wdata;

  cpu_dcache #(.INDEX_BITS(8)) dut (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .o_bus_rw      (o_bus_rw),
    .o_bus_request (o_bus_request),
    .i_bus_ready   (i_bus_ready),
    .o_bus_address (o_bus_address),
    .i_bus_rdata   (i_bus_rdata),
    .o_bus_wdata   (o_bus_wdata),
    .i_rw          (i_rw),
    .i_request     (i_request),
    .o_ready       (o_ready),
    .i_address     (i_address),
    .o_rdata       (o_rdata),
    .i_wdata       (i_wdata)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] exp_q [$];
  logic [31:0] bus_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  int          n_bus_rd = 0;
  int          n_bus_wr = 0;
  logic [31:0] last_bus_addr = '0;
  logic [31:0] last_bus_wdata = '0;
  logic        bus_enable = 1'b1;
  int          bus_delay = 2;

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] bus_pattern(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // Bus memory: acknowledges a request bus_delay+1 cycles after it appears.
  initial begin : bus_responder
    int wait_cnt;
    wait_cnt    = 0;
    i_bus_ready = 1'b0;
    i_bus_rdata = '0;
    forever begin
      @(negedge i_clock);
      i_bus_ready = 1'b0;
      if (o_bus_request && bus_enable) begin
        if (wait_cnt == bus_delay) begin
          wait_cnt      = 0;
          i_bus_ready   = 1'b1;
          last_bus_addr = o_bus_address;
          if (o_bus_rw) begin
            n_bus_wr++;
            last_bus_wdata = o_bus_wdata;
            bus_mem[o_bus_address] = o_bus_wdata;
          end else begin
            n_bus_rd++;
            i_bus_rdata = bus_mem.exists(o_bus_address) ? bus_mem[o_bus_address]
                                                        : bus_pattern(o_bus_address);
          end
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Scoreboard check on each completion, plus protocol checks on the outputs.
  initial begin : monitor
    logic        prev_ready;
    logic        prev_req;
    logic [31:0] prev_addr;
    logic [31:0] e;
    prev_ready = 1'b0;
    prev_req   = 1'b0;
    prev_addr  = '0;
    forever begin
      @(negedge i_clock);
      if (o_ready) begin
        expect_eq("ready_gap", {31'd0, prev_ready}, 32'd0);
        if (exp_q.size() == 0) begin
          expect_eq("spurious_ready", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          expect_eq("rdata", o_rdata, e);
        end
      end
      if (o_bus_request && prev_req)
        expect_eq("bus_addr_stable", o_bus_address, prev_addr);
      prev_ready = o_ready;
      prev_req   = o_bus_request;
      prev_addr  = o_bus_address;
    end
  end

  // One CPU transaction; returns cycles from request to o_ready.
  task automatic cpu_access(input logic rw, input logic [31:0] a,
                            input logic [31:0] wd, output int lat);
    logic [31:0] exp;
    @(posedge i_clock); #1;
    i_rw      = rw;
    i_address = a;
    i_wdata   = wd;
    i_request = 1'b1;
    if (rw) begin
      ref_mem[a] = wd;
      exp = wd;
    end else begin
      exp = ref_mem.exists(a) ? ref_mem[a] : bus_pattern(a);
    end
    exp_q.push_back(exp);
    lat = 0;
    do begin
      @(posedge i_clock); #1;
      lat++;
    end while (!o_ready && lat < 200);
    if (!o_ready) begin
      expect_eq("cpu_timeout", 32'd0, 32'd1);
      exp_q.delete();
      i_request = 1'b0;
    end else begin
      @(posedge i_clock); #1;
      i_request = 1'b0;
    end
  endtask

  task automatic read_expect(input string tag, input logic [31:0] a, input int exp_bus_rd);
    int lat;
    int rd0;
    rd0 = n_bus_rd;
    cpu_access(1'b0, a, 32'd0, lat);
    expect_eq(tag, n_bus_rd - rd0, exp_bus_rd);
  endtask

  initial begin : main
    int lat;
    int rd0;
    int wr0;
    i_reset   = 1'b0;
    i_request = 1'b0;
    i_rw      = 1'b0;
    i_address = '0;
    i_wdata   = '0;
    bus_mem[32'h0000_1000] = 32'hDEAD_BEEF;
    ref_mem[32'h0000_1000] = 32'hDEAD_BEEF;

    repeat (3) @(posedge i_clock);
    #1;
    expect_eq("rst_bus_request", {31'd0, o_bus_request}, 32'd0);
    expect_eq("rst_bus_rw",      {31'd0, o_bus_rw},      32'd0);
    expect_eq("rst_ready",       {31'd0, o_ready},       32'd0);
    expect_eq("rst_bus_address", o_bus_address,          32'd0);
    expect_eq("rst_bus_wdata",   o_bus_wdata,            32'd0);
    expect_eq("rst_rdata",       o_rdata,                32'd0);
    i_reset = 1'b1;

    // Cold miss, then hit with two-cycle latency.
    rd0 = n_bus_rd;
    cpu_access(1'b0, 32'h0000_1000, 32'd0, lat);
    expect_eq("miss_bus_reads", n_bus_rd - rd0, 32'd1);
    expect_eq("miss_bus_addr",  last_bus_addr,  32'h0000_1000);
    rd0 = n_bus_rd;
    cpu_access(1'b0, 32'h0000_1000, 32'd0, lat);
    expect_eq("hit_bus_reads", n_bus_rd - rd0, 32'd0);
    expect_eq("hit_latency",   lat,            32'd2);

    // Write-through then read hit of the new data.
    rd0 = n_bus_rd;
    wr0 = n_bus_wr;
    cpu_access(1'b1, 32'h0000_1000, 32'h1234_5678, lat);
    expect_eq("wr_bus_writes", n_bus_wr - wr0, 32'd1);
    expect_eq("wr_bus_wdata",  last_bus_wdata, 32'h1234_5678);
    expect_eq("wr_bus_addr",   last_bus_addr,  32'h0000_1000);
    read_expect("wr_then_hit", 32'h0000_1000, 0);
    expect_eq("wr_no_bus_read", n_bus_rd - rd0, 32'd0);

    // Write-allocate on a miss: a following read hits.
    cpu_access(1'b1, 32'h0000_0C08, 32'hA5A5_0F0F, lat);
    read_expect("alloc_hit", 32'h0000_0C08, 0);

    // Index conflict: lines 0x004 and 0x404 share index 1.
    read_expect("conflict_a",  32'h0000_0004, 1);
    read_expect("conflict_b",  32'h0000_0404, 1);
    read_expect("conflict_a2", 32'h0000_0004, 1);

    // I/O region behaviour depends on the build option.
    read_expect("io_first", 32'h8000_0010, 1);
`ifdef DCACHE_UNCACHED_IO_EN
    read_expect("io_second", 32'h8000_0010, 1);
`else
    read_expect("io_second", 32'h8000_0010, 0);
`endif

    // Reset in the middle of a bus read that the bus never answers.
    bus_enable = 1'b0;
    @(posedge i_clock); #1;
    i_rw      = 1'b0;
    i_address = 32'h0000_2000;
    i_request = 1'b1;
    repeat (4) @(posedge i_clock);
    #1;
    expect_eq("abort_pre_request", {31'd0, o_bus_request}, 32'd1);
    #2;
    i_reset = 1'b0;
    #1;
    expect_eq("abort_request_drop", {31'd0, o_bus_request}, 32'd0);
    i_request = 1'b0;
    @(posedge i_clock); #1;
    i_reset    = 1'b1;
    bus_enable = 1'b1;
    read_expect("abort_then_miss", 32'h0000_2000, 1);
    read_expect("post_rst_cold",   32'h0000_1000, 1);
    read_expect("post_rst_hit",    32'h0000_1000, 0);

    repeat (4) @(posedge i_clock);
    expect_eq("scoreboard_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
